btpipe_out_arbiter: RTL

Shares one block-throttled pipe-out endpoint between N_SRC data sources, e.g. per-channel acquisition FIFOs. Grants the pipe one whole block at a time, in round-robin order, to each enabled source holding at least BLOCK_WORDS words. Drives the endpoint ready flag and steers the endpoint read strobe to the granted source's read port. Sits between the source FIFOs and the pipe-out endpoint in the ti_clk domain.

---
 rtl/btpipe_out_arbiter_if.sv | 31 +++
 rtl/btpipe_out_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/btpipe_out_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : btpipe_out_arbiter_if
//  Description : Block-throttled pipe-out endpoint handshake bundle. The
//                endpoint side (master) drives read/blockstrobe; the
//                arbiter side (slave) drives ready/data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface btpipe_out_arbiter_if #(
    parameter int DW = 16
) ();
    logic          pipe_out_read;
    logic          pipe_out_blockstrobe;
    logic          pipe_out_ready;
    logic [DW-1:0] pipe_out_data;

    modport master (
        output pipe_out_read,
        output pipe_out_blockstrobe,
        input  pipe_out_ready,
        input  pipe_out_data
    );

    modport slave (
        input  pipe_out_read,
        input  pipe_out_blockstrobe,
        output pipe_out_ready,
        output pipe_out_data
    );
endinterface
`default_nettype wire

// File: rtl/btpipe_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : btpipe_out_arbiter
//  Description : Round-robin, block-granular arbiter sharing one pipe-out
//                endpoint between N_SRC source FIFOs. A source is granted
//                one whole block when enabled and holding BLOCK_WORDS words.
//  Revision    : 1.0 - initial release
// ============================================================================
module btpipe_out_arbiter #(
    parameter int N_SRC       = 4,
    parameter int BLOCK_WORDS = 256,
    parameter int DW          = 16,
    parameter int CNT_W       = 11
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    btpipe_out_arbiter_if.slave         pipe,
    input  wire logic [N_SRC-1:0]       enable,
    input  wire logic [N_SRC*CNT_W-1:0] src_count,
    output logic      [N_SRC-1:0]       src_rd,
    input  wire logic [N_SRC*DW-1:0]    src_data,
    output logic      [2:0]             grant_id,
    output logic                        busy,
    output logic      [15:0]            blocks_done,
    output logic                        error
);

    localparam int                WC_W     = $clog2(BLOCK_WORDS + 1);
    localparam logic [CNT_W-1:0]  C_THRESH = CNT_W'(BLOCK_WORDS);
    localparam logic [WC_W-1:0]   C_LAST   = WC_W'(BLOCK_WORDS - 1);
    localparam logic [2:0]        C_GRANT0 = 3'(N_SRC - 1);
    localparam logic [3:0]        C_NSRC   = 4'(N_SRC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_grant;
    logic [2:0]        w_grant_nxt;
    logic [WC_W-1:0]   r_word_cnt;
    logic [WC_W-1:0]   w_word_cnt_nxt;
    logic [15:0]       r_blocks;
    logic [15:0]       w_blocks_nxt;
    logic              r_error;
    logic              w_error_nxt;
    logic [2:0]        r_sel;
    logic [DW-1:0]     r_data;
    logic [DW-1:0]     w_mux;
    logic [N_SRC-1:0]  w_elig;
    logic [7:0]        w_elig_ext;
    logic              w_found;
    logic [2:0]        w_pick;
    logic              w_read;
    logic              w_strobe;

    assign w_read   = pipe.pipe_out_read;
    assign w_strobe = pipe.pipe_out_blockstrobe;

    // A source is eligible when enabled and holding at least one full block.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_elig
            assign w_elig[gi] = enable[gi] &&
                                (src_count[gi*CNT_W +: CNT_W] >= C_THRESH);
        end
    endgenerate

    assign w_elig_ext = 8'(w_elig);

    // Round-robin search: first eligible index upward from the last grant.
    always_comb begin
        logic [3:0] v_idx;
        w_found = 1'b0;
        w_pick  = r_grant;
        for (int k = 1; k <= N_SRC; k++) begin
            v_idx = {1'b0, r_grant} + 4'(k);
            if (v_idx >= C_NSRC) begin
                v_idx = v_idx - C_NSRC;
            end
            if (!w_found && w_elig_ext[v_idx[2:0]]) begin
                w_found = 1'b1;
                w_pick  = v_idx[2:0];
            end
        end
    end

    // Next-state, grant, word counter, block counter and error logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_word_cnt_nxt = r_word_cnt;
        w_blocks_nxt   = r_blocks;
        w_error_nxt    = r_error;
        case (r_state)
            ST_IDLE: begin
                if (w_read) begin
                    w_error_nxt = 1'b1;
                end
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                // Reads before the blockstrobe are illegal and dropped.
                if (w_read) begin
                    w_error_nxt = 1'b1;
                end
                if (w_strobe) begin
                    w_word_cnt_nxt = '0;
                    w_state_nxt    = ST_XFER;
                end
            end
            ST_XFER: begin
                // A second blockstrobe mid-block is flagged but does not
                // restart the word count.
                if (w_strobe) begin
                    w_error_nxt = 1'b1;
                end
                if (w_read) begin
                    if (r_word_cnt == C_LAST) begin
                        w_word_cnt_nxt = '0;
                        w_blocks_nxt   = r_blocks + 16'd1;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= C_GRANT0;
            r_word_cnt <= '0;
            r_blocks   <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_blocks   <= w_blocks_nxt;
            r_error    <= w_error_nxt;
        end
    end

    // Read strobe steering: only the granted source sees the endpoint read,
    // and only while a block is in flight.
    always_comb begin
        src_rd = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_rd[i] = (r_state == ST_XFER) && w_read && (r_grant == 3'(i));
        end
    end

    // Data mux keyed by a registered grant copy, isolating the wide mux
    // from the arbitration logic.
    always_comb begin
        w_mux = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_sel == 3'(i)) begin
                w_mux = src_data[i*DW +: DW];
            end
        end
    end

    // Data path register feeding the endpoint.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel  <= C_GRANT0;
            r_data <= '0;
        end else begin
            r_sel  <= r_grant;
            r_data <= w_mux;
        end
    end

    assign pipe.pipe_out_ready = (r_state == ST_READY);
    assign pipe.pipe_out_data  = r_data;
    assign grant_id            = r_grant;
    assign busy                = (r_state != ST_IDLE);
    assign blocks_done         = r_blocks;
    assign error               = r_error;

endmodule
`default_nettype wire
